// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the iterative RV32M mul/div unit.
// The master side launches operations; the slave side reports busy/done/result.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            startE;
    logic [2:0]      funct3E;
    logic [XLEN-1:0] SrcAE;
    logic [XLEN-1:0] SrcBE;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output startE, funct3E, SrcAE, SrcBE, flush,
        input  busy, done, result
    );

    modport slave (
        input  startE, funct3E, SrcAE, SrcBE, flush,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         reset,
    muldiv_unit_if.slave bus
);
    localparam int CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              neg_q, neg_d;
    logic              special_q, special_d;
    logic              done_q, done_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic            is_div, a_signed, b_signed, a_neg, b_neg, start_neg;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, div_ovf;
    logic [XLEN-1:0] special_res;
    logic [XLEN:0]   mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] prod_fin;
    logic [XLEN-1:0] quo_fin, rem_fin, fin_res;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
`endif

    // Operand decode at launch: signedness per funct3, magnitudes and result sign.
    always_comb begin
        is_div    = bus.funct3E[2];
        a_signed  = is_div ? !bus.funct3E[0] : (bus.funct3E[1:0] != 2'b11);
        b_signed  = is_div ? !bus.funct3E[0] : !bus.funct3E[1];
        a_neg     = a_signed & bus.SrcAE[XLEN-1];
        b_neg     = b_signed & bus.SrcBE[XLEN-1];
        a_abs     = a_neg ? -bus.SrcAE : bus.SrcAE;
        b_abs     = b_neg ? -bus.SrcBE : bus.SrcBE;
        // Remainder takes the dividend's sign; quotient and product take the XOR.
        start_neg = (bus.funct3E[2] & bus.funct3E[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = is_div && (bus.SrcBE == '0);
        div_ovf   = is_div && !bus.funct3E[0] && (bus.SrcAE == MOST_NEG) && (bus.SrcBE == '1);
        if (div_zero)
            special_res = bus.funct3E[1] ? bus.SrcAE : '1;
        else
            special_res = bus.funct3E[1] ? '0 : MOST_NEG;
`ifdef MULDIV_FAST_MUL_EN
        fast_a    = a_signed ? {{XLEN{bus.SrcAE[XLEN-1]}}, bus.SrcAE} : {{XLEN{1'b0}}, bus.SrcAE};
        fast_b    = b_signed ? {{XLEN{bus.SrcBE[XLEN-1]}}, bus.SrcBE} : {{XLEN{1'b0}}, bus.SrcBE};
        fast_prod = fast_a * fast_b;
`endif
    end

    // Iteration datapath: acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
        div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, b_q};
        prod_fin  = neg_q ? -acc_q : acc_q;
        quo_fin   = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rem_fin   = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
        if (special_q) begin
            fin_res = acc_q[XLEN-1:0];
        end else begin
            unique case (op_q)
                3'b000:                 fin_res = prod_fin[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fin_res = prod_fin[2*XLEN-1:XLEN];
                3'b100, 3'b101:         fin_res = quo_fin;
                default:                fin_res = rem_fin;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        acc_d     = acc_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        neg_d     = neg_q;
        special_d = special_q;
        done_d    = 1'b0;
        result_d  = result_q;
        unique case (state_q)
            IDLE: begin
                if (bus.startE && !bus.flush) begin
                    op_d      = bus.funct3E;
                    neg_d     = start_neg;
                    special_d = 1'b0;
                    cnt_d     = CNT_W'(XLEN);
                    acc_d     = {{XLEN{1'b0}}, (is_div ? a_abs : b_abs)};
                    b_d       = is_div ? b_abs : a_abs;
                    state_d   = CALC;
                    if (div_zero || div_ovf) begin
                        special_d = 1'b1;
                        acc_d     = {{XLEN{1'b0}}, special_res};
                        state_d   = DONE;
                    end
`ifdef MULDIV_FAST_MUL_EN
                    if (!is_div) begin
                        acc_d   = fast_prod;
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end
`endif
                end
            end
            CALC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (op_q[2]) begin
                    if (!div_diff[XLEN])
                        acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
                    else
                        acc_d = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
                end else begin
                    acc_d = {mul_sum, acc_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_W'(1))
                    state_d = DONE;
            end
            DONE: begin
                result_d = fin_res;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (bus.flush) begin
            state_d  = IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            acc_q     <= '0;
            b_q       <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            special_q <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            acc_q     <= acc_d;
            b_q       <= b_d;
            cnt_q     <= cnt_d;
            neg_q     <= neg_d;
            special_q <= special_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign bus.busy   = (state_q == CALC);
    assign bus.done   = done_q;
    assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit with hand-computed RV32M results.
module tb_muldiv_unit;
    localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    muldiv_unit_if #(.XLEN(XLEN)) bus_if ();

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Drives a start pulse; returns 1 time unit after the accepting edge.
    task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus_if.startE  = 1'b1;
        bus_if.funct3E = f;
        bus_if.SrcAE   = a;
        bus_if.SrcBE   = b;
        @(posedge clk);
        #1;
        bus_if.startE  = 1'b0;
        bus_if.funct3E = 3'b111;
        bus_if.SrcAE   = 32'hDEAD_BEEF;
        bus_if.SrcBE   = 32'h0BAD_F00D;
    endtask

    task automatic wait_done(input int lat0, output int lat, output bit seen);
        lat  = lat0;
        seen = 1'b0;
        while (!seen && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
            if (bus_if.done) seen = 1'b1;
        end
    endtask

    task automatic expect_no_done(input string tag, input int n);
        int pulses;
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.done) pulses++;
        end
        check(tag, 32'(pulses), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        bit seen;
        start_op(f, a, b);
        check({tag, "_busy"}, 32'(bus_if.busy), (exp_lat > 1) ? 32'd1 : 32'd0);
        wait_done(0, lat, seen);
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_res"}, bus_if.result, exp_res);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(bus_if.done), 32'd0);
        check({tag, "_hold"}, bus_if.result, exp_res);
    endtask

    initial begin
        int  lat;
        bit  seen;
        checks = 0;
        errors = 0;
        reset = 1'b1;
        bus_if.startE  = 1'b0;
        bus_if.funct3E = 3'b000;
        bus_if.SrcAE   = '0;
        bus_if.SrcBE   = '0;
        bus_if.flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_done", 32'(bus_if.done), 32'd0);
        check("rst_result", bus_if.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Multiply variants
        run_op("mul_m1x3",    F_MUL,    32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFD, MUL_LAT);
        run_op("mulhu_m1x3",  F_MULHU,  32'hFFFF_FFFF, 32'h0000_0003, 32'h0000_0002, MUL_LAT);
        run_op("mulh_m1x3",   F_MULH,   32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mulhsu_3xu",  F_MULHSU, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0000_0002, MUL_LAT);
        run_op("mulhsu_m1x3", F_MULHSU, 32'hFFFF_FFFF, 32'h0000_0003, 32'hFFFF_FFFF, MUL_LAT);
        run_op("mulh_min2",   F_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, MUL_LAT);
        run_op("mul_7x6",     F_MUL,    32'd7,         32'd6,         32'd42,        MUL_LAT);

        // Divide variants
        run_op("div_m20_6",   F_DIV,  32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_m20_6",   F_REM,  32'hFFFF_FFEC, 32'd6,         32'hFFFF_FFFE, DIV_LAT);
        run_op("divu_20_6",   F_DIVU, 32'd20,        32'd6,         32'd3,         DIV_LAT);
        run_op("remu_20_6",   F_REMU, 32'd20,        32'd6,         32'd2,         DIV_LAT);
        run_op("div_20_m6",   F_DIV,  32'd20,        32'hFFFF_FFFA, 32'hFFFF_FFFD, DIV_LAT);
        run_op("rem_20_m6",   F_REM,  32'd20,        32'hFFFF_FFFA, 32'd2,         DIV_LAT);
        run_op("divu_big_6",  F_DIVU, 32'hFFFF_FFEC, 32'd6,         32'h2AAA_AAA7, DIV_LAT);

        // Special cases finishing in one cycle
        run_op("div_by0",     F_DIV,  32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("rem_by0",     F_REM,  32'h1234_5678, 32'd0,         32'h1234_5678, 1);
        run_op("divu_by0",    F_DIVU, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1);
        run_op("remu_by0",    F_REMU, 32'h1234_5678, 32'd0,         32'h1234_5678, 1);
        run_op("div_ovf",     F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("rem_ovf",     F_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        run_op("divu_novf",   F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, DIV_LAT);
        run_op("remu_novf",   F_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, DIV_LAT);

        // Reset during CALC discards the operation
        start_op(F_DIV, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_done", 32'(bus_if.done), 32'd0);
        check("midrst_result", bus_if.result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        expect_no_done("midrst_nodone", 40);

        // Establish a known result, then flush a divu mid-flight
        run_op("divu_pre", F_DIVU, 32'd77, 32'd7, 32'd11, DIV_LAT);
        start_op(F_DIVU, 32'd1000, 32'd3);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("flush_busy_before", 32'(bus_if.busy), 32'd1);
        @(negedge clk);
        bus_if.flush = 1'b1;
        @(posedge clk);
        #1;
        bus_if.flush = 1'b0;
        check("flush_busy", 32'(bus_if.busy), 32'd0);
        check("flush_done", 32'(bus_if.done), 32'd0);
        check("flush_result", bus_if.result, 32'd11);
        run_op("divu_9_3", F_DIVU, 32'd9, 32'd3, 32'd3, DIV_LAT);

        // flush and start together in IDLE: the start is dropped
        @(negedge clk);
        bus_if.startE  = 1'b1;
        bus_if.flush   = 1'b1;
        bus_if.funct3E = F_DIVU;
        bus_if.SrcAE   = 32'd50;
        bus_if.SrcBE   = 32'd5;
        @(posedge clk);
        #1;
        bus_if.startE = 1'b0;
        bus_if.flush  = 1'b0;
        check("flushstart_busy", 32'(bus_if.busy), 32'd0);
        expect_no_done("flushstart_nodone", 40);
        check("flushstart_result", bus_if.result, 32'd3);

        // startE while busy is ignored
        start_op(F_DIVU, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        bus_if.startE  = 1'b1;
        bus_if.funct3E = F_MUL;
        bus_if.SrcAE   = 32'd5;
        bus_if.SrcBE   = 32'd5;
        @(posedge clk);
        #1;
        bus_if.startE = 1'b0;
        wait_done(4, lat, seen);
        check("busystart_seen", 32'(seen), 32'd1);
        check("busystart_lat", 32'(lat), 32'(DIV_LAT));
        check("busystart_res", bus_if.result, 32'd14);
        expect_no_done("busystart_nodone", 40);
        check("busystart_hold", bus_if.result, 32'd14);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit for the RV32M extension, XLEN-parametrised. It sits beside the ALU in the execute stage. The unit accepts one operation per start pulse and computes one bit per cycle. It holds busy so the hazard unit can stall the pipeline, then pulses done with the result. It covers mul/mulh/mulhsu/mulhu/div/divu/rem/remu, which the single-cycle ALU does not.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8.
CNT_W, $clog2(XLEN)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
startE  input  1  launch operation; sampled only when busy=0
funct3E  input  3  op select: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu
SrcAE  input  XLEN  rs1 operand (multiplicand / dividend)
SrcBE  input  XLEN  rs2 operand (multiplier / divisor)
flush  input  1  abort the in-flight operation (branch mispredict / trap)
busy  output  1  high from the cycle after accepted start until done (inclusive of CALC, exclusive of DONE)
done  output  1  one-cycle pulse, result valid
result  output  XLEN  operation result; held stable until next accepted start

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result=0, counter=0, internal accumulators=0. Reset mid-operation discards the work; no done is issued.
- FSM states: IDLE, CALC, DONE.
  - IDLE→CALC on startE=1: latch funct3E and operands; take abs() of signed operands; record result sign. Counter=XLEN.
  - IDLE→DONE directly for division special cases, which finish with latency 1.
  - CALC: one iteration per cycle; counter decrements; CALC→DONE when counter reaches 1 on the final iteration. Normal latency is XLEN+1 cycles from the start edge to done=1 (33 for XLEN=32).
  - DONE: done=1 for exactly one cycle; result registered; DONE→IDLE unconditionally. startE during DONE is ignored.
- Multiply: shift-add over a 2*XLEN product.
  - mul returns the low XLEN bits.
  - mulh/mulhsu/mulhu return the high XLEN bits.
  - Signedness: mulh is signed×signed, mulhsu is signed SrcAE × unsigned SrcBE, mulhu is unsigned×unsigned. Negate the 2*XLEN product if the sign flag is set.
- Divide: restoring, one quotient bit per cycle.
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- Division special cases (no CALC):
  - Divisor=0: div/divu return all-ones; rem/remu return SrcAE.
  - Signed overflow (SrcAE=most-negative, SrcBE=-1): div returns most-negative; rem returns 0.
- flush: any state→IDLE next cycle; busy=0; done not asserted; result unchanged. flush has priority over startE in the same cycle. flush+startE in IDLE: start is dropped.
- Operand inputs are don't-care after acceptance; internal copies are used.

Optional Feature:
Macro MULDIV_FAST_MUL_EN.
- Defined: multiply ops use a single-cycle combinational XLEN×XLEN signed-extended multiplier. IDLE→DONE directly, so multiply latency is 1 (done on the cycle after start, busy never asserts). Divide is unchanged.
- Undefined: multiply uses the iterative path, XLEN+1 latency. No DSP/multiplier inference.

Test Plan:
- Reset while in CALC after div 100/7 started → busy=0, done never pulses; next cycle state IDLE, result=0.
- mul SrcAE=0xFFFFFFFF (-1), SrcBE=0x00000003 → done at cycle 33 (iterative) or 1 (FAST_MUL_EN), result=0xFFFFFFFD. mulhu same operands → 0x00000002. mulh same operands → 0xFFFFFFFF.
- div SrcAE=-20 (0xFFFFFFEC), SrcBE=6 → result 0xFFFFFFFD (-3). rem same operands → 0xFFFFFFFE (-2). divu 20/6 → 3. remu 20/6 → 2.
- Division by zero: div 0x12345678/0 → done 1 cycle after start, result 0xFFFFFFFF; rem 0x12345678/0 → 0x12345678.
- Overflow: div 0x80000000/0xFFFFFFFF → result 0x80000000 in 1 cycle; rem same operands → 0.
- flush at cycle 10 of divu 1000/3 → busy=0 next cycle, no done pulse. Immediate new startE divu 9/3 → done after 33 cycles, result 3. startE asserted while busy=1 → ignored, result unaffected.
